// File: rtl/path_meter_pkg.sv
// path_meter_pkg
//   Shared definitions for the path_delay_meter block: measurement FSM states,
//   synchroniser depth and the phase-counter type used for the warm-up and
//   gate windows.
package path_meter_pkg;
    timeunit 1ps;
    timeprecision 1ps;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWarm  = 2'd1,
        StCount = 2'd2,
        StDone  = 2'd3
    } meter_state_e;

    // Flops between the free-running ring and the clk domain.
    localparam int unsigned SYNC_STAGES = 2;

    // Cycle counter for the warm-up and gate windows; unused upper bits
    // are constant and drop out in synthesis.
    typedef logic [31:0] count_w_t;
endpackage

// File: rtl/ring_delay_chain.sv
// ring_delay_chain
//   CHAIN_LEN delay stages closed into a gated ring oscillator. The head is a
//   NAND of enable and the chain output, so the ring oscillates while enable
//   is high and rests at 1 while it is low. Every net is kept so synthesis
//   cannot collapse the chain.
// Ports:
//   enable   - ring enable, active high
//   ring_out - chain output (period ~ 2 * CHAIN_LEN * stage delay)
module ring_delay_chain #(
    parameter int unsigned CHAIN_LEN      = 50,
    parameter int unsigned STAGE_DELAY_PS = 1000
) (
    input  logic enable,
    output logic ring_out
);
    timeunit 1ps;
    timeprecision 1ps;

    (* keep *) logic [CHAIN_LEN:0] tap;

    // NAND head closes the loop; it is the only inverting element.
    assign tap[0] = ~(enable & ring_out);

    for (genvar i = 0; i < CHAIN_LEN; i++) begin : g_stage
        (* keep *) singlepath_plode #(
            .DELAY_PS(STAGE_DELAY_PS)
        ) u_stage (
            .a(tap[i]),
            .y(tap[i+1])
        );
    end

    assign ring_out = tap[CHAIN_LEN];
endmodule

// File: rtl/singlepath_plode.sv
// singlepath_plode
//   Single non-inverting delay stage used to build measurement rings.
//   DELAY_PS only shapes simulation timing; the physical delay comes from
//   the cell itself.
// Ports:
//   a - stage input
//   y - delayed copy of a
module singlepath_plode #(
    parameter int unsigned DELAY_PS = 1000
) (
    input  logic a,
    output logic y
);
    timeunit 1ps;
    timeprecision 1ps;

    assign #(DELAY_PS) y = a;
endmodule

// File: rtl/path_delay_meter.sv
// path_delay_meter
//   Runs one of N_CH delay-chain ring oscillators for a warm-up period and a
//   fixed gate window, counting synchronised rising ring edges. A loaded
//   (trojan-tapped) chain runs slower and returns a lower count.
// Ports:
//   clk      - system clock
//   rst      - synchronous active-high reset
//   start    - measurement request, sampled in idle only
//   ch_sel   - chain to measure, latched with start
//   busy     - measurement in progress (until done is left)
//   done     - one-cycle pulse, result valid
//   count    - rising-edge count of last measurement
//   overflow - count saturated during last measurement
//   sel_err  - last start carried an out-of-range ch_sel
module path_delay_meter
    import path_meter_pkg::*;
#(
    parameter int unsigned     N_CH           = 4,
    parameter int unsigned     CHAIN_LEN      = 50,
    parameter int unsigned     WARM_CYCLES    = 16,
    parameter int unsigned     GATE_CYCLES    = 1024,
    parameter int unsigned     CNT_W          = 16,
    parameter int unsigned     SEL_W          = (N_CH > 1) ? $clog2(N_CH) : 1,
    parameter int unsigned     STAGE_DELAY_PS = 1000,
    parameter int unsigned     SLOW_DELAY_PS  = 1100,
    parameter logic [N_CH-1:0] SLOW_MASK      = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [SEL_W-1:0] ch_sel,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic             sel_err
);
    timeunit 1ps;
    timeprecision 1ps;

    meter_state_e     state_q, state_d;
    count_w_t         phase_q, phase_d;
    logic [SEL_W-1:0] ch_q, ch_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             sel_err_q, sel_err_d;
    logic [N_CH-1:0]  ring_en_q, ring_en_d;

    logic [N_CH-1:0]        ring_raw;
    logic                   ring_mux;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise;
    logic                   sel_ok;
    logic                   running_d;

    // Rings; channels flagged in SLOW_MASK model a loaded (slower) chain.
    for (genvar g = 0; g < N_CH; g++) begin : g_chain
        ring_delay_chain #(
            .CHAIN_LEN     (CHAIN_LEN),
            .STAGE_DELAY_PS(SLOW_MASK[g] ? SLOW_DELAY_PS : STAGE_DELAY_PS)
        ) u_chain (
            .enable  (ring_en_q[g]),
            .ring_out(ring_raw[g])
        );
    end

    // Channel mux; written as a compare loop so a wide ch_q never indexes
    // past the last chain.
    always_comb begin
        ring_mux = 1'b1;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (32'(ch_q) == i) begin
                ring_mux = ring_raw[i];
            end
        end
    end

    assign rise   = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign sel_ok = 32'(ch_sel) < N_CH;

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        ch_d      = ch_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        sel_err_d = sel_err_q;
        ring_en_d = '0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    count_d = '0;
                    ovf_d   = 1'b0;
                    if (sel_ok) begin
                        ch_d      = ch_sel;
                        sel_err_d = 1'b0;
                        phase_d   = count_w_t'(WARM_CYCLES - 1);
                        state_d   = StWarm;
                    end else begin
                        sel_err_d = 1'b1;
                        state_d   = StDone;
                    end
                end
            end
            StWarm: begin
                if (phase_q == '0) begin
                    phase_d = count_w_t'(GATE_CYCLES - 1);
                    state_d = StCount;
                end else begin
                    phase_d = phase_q - 1;
                end
            end
            StCount: begin
                if (rise) begin
                    // Saturate; overflow marks an edge lost at all-ones.
                    if (count_q == '1) begin
                        ovf_d = 1'b1;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
                if (phase_q == '0) begin
                    state_d = StDone;
                end else begin
                    phase_d = phase_q - 1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Enable follows the next state so the ring starts on acceptance and
        // stops on the edge that leaves the gate window.
        running_d = (state_d == StWarm) || (state_d == StCount);
        for (int unsigned i = 0; i < N_CH; i++) begin
            ring_en_d[i] = running_d && (32'(ch_d) == i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            phase_q   <= '0;
            ch_q      <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            sel_err_q <= 1'b0;
            ring_en_q <= '0;
            sync_q    <= '1;
            prev_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            ch_q      <= ch_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            sel_err_q <= sel_err_d;
            ring_en_q <= ring_en_d;
            sync_q    <= {sync_q[SYNC_STAGES-2:0], ring_mux};
            prev_q    <= sync_q[SYNC_STAGES-1];
        end
    end

    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StDone);
    assign count    = count_q;
    assign overflow = ovf_q;
    assign sel_err  = sel_err_q;
endmodule

// File: tb/tb_path_delay_meter.sv
// tb_path_delay_meter
//   Self-checking bench for path_delay_meter. Expected counts come from the
//   ring period (2 * CHAIN_LEN * stage delay) against the gate window length.
module tb_path_delay_meter;
    timeunit 1ps;
    timeprecision 1ps;
    import path_meter_pkg::*;

    localparam int unsigned     N_CH      = 4;
    localparam int unsigned     CHAIN_LEN = 50;
    localparam int unsigned     WARM      = 16;
    localparam int unsigned     GATE      = 1024;
    localparam int unsigned     SEL_W     = 3;
    localparam int unsigned     CLK_PS    = 10000;
    localparam int unsigned     FAST_PS   = 1000;
    localparam int unsigned     SLOW_PS   = 1100;
    localparam logic [N_CH-1:0] SLOW_MASK = 4'b0100;

    logic             clk = 1'b0;
    logic             rst;
    logic             start, start_o;
    logic [SEL_W-1:0] ch_sel, ch_sel_o;
    logic             busy, done, overflow, sel_err;
    logic [15:0]      count;
    logic             busy_o, done_o, overflow_o, sel_err_o;
    logic [3:0]       count_o;

    int checks = 0;
    int errors = 0;

    always #(CLK_PS / 2) clk = ~clk;

    path_delay_meter #(
        .N_CH          (N_CH),
        .CHAIN_LEN     (CHAIN_LEN),
        .WARM_CYCLES   (WARM),
        .GATE_CYCLES   (GATE),
        .CNT_W         (16),
        .SEL_W         (SEL_W),
        .STAGE_DELAY_PS(FAST_PS),
        .SLOW_DELAY_PS (SLOW_PS),
        .SLOW_MASK     (SLOW_MASK)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .ch_sel  (ch_sel),
        .busy    (busy),
        .done    (done),
        .count   (count),
        .overflow(overflow),
        .sel_err (sel_err)
    );

    path_delay_meter #(
        .N_CH          (N_CH),
        .CHAIN_LEN     (CHAIN_LEN),
        .WARM_CYCLES   (WARM),
        .GATE_CYCLES   (GATE),
        .CNT_W         (4),
        .SEL_W         (SEL_W),
        .STAGE_DELAY_PS(FAST_PS),
        .SLOW_DELAY_PS (SLOW_PS),
        .SLOW_MASK     ('0)
    ) u_ovf (
        .clk     (clk),
        .rst     (rst),
        .start   (start_o),
        .ch_sel  (ch_sel_o),
        .busy    (busy_o),
        .done    (done_o),
        .count   (count_o),
        .overflow(overflow_o),
        .sel_err (sel_err_o)
    );

    // Nominal rising edges seen in the gate window; synchroniser phase adds +1.
    function automatic int unsigned exp_edges(input int unsigned delay_ps);
        return (GATE * CLK_PS) / (2 * CHAIN_LEN * delay_ps);
    endfunction

    task automatic tick();
        @(posedge clk);
        #100;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int unsigned obs,
                               input int unsigned lo, input int unsigned hi);
        checks++;
        assert (obs >= lo && obs <= hi)
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic measure_main(input int unsigned ch, input string tag);
        int unsigned     lo;
        int unsigned     lat;
        logic [N_CH-1:0] exp_en;
        bit              en_bad;
        lo        = exp_edges(SLOW_MASK[ch] ? SLOW_PS : FAST_PS);
        exp_en    = '0;
        exp_en[ch] = 1'b1;
        ch_sel = SEL_W'(ch);
        start  = 1'b1;
        tick();
        start  = 1'b0;
        check({tag, " busy_after_accept"}, 32'(busy), 32'd1);
        check({tag, " en_after_accept"}, 32'(u_dut.ring_en_q), 32'(exp_en));
        check({tag, " count_cleared"}, 32'(count), 32'd0);
        check({tag, " sel_err_cleared"}, 32'(sel_err), 32'd0);
        lat    = 0;
        en_bad = 1'b0;
        for (int k = 1; k <= int'(WARM + GATE + 20); k++) begin
            tick();
            if (done) begin
                lat = k;
                break;
            end
            if (u_dut.ring_en_q !== exp_en) en_bad = 1'b1;
        end
        check({tag, " done_latency"}, lat, WARM + GATE);
        check({tag, " only_sel_enabled"}, 32'(en_bad), 32'd0);
        check_range({tag, " count"}, 32'(count), lo, lo + 1);
        check({tag, " overflow"}, 32'(overflow), 32'd0);
        check({tag, " en_off_at_done"}, 32'(u_dut.ring_en_q), 32'd0);
        tick();
        check({tag, " done_pulse_1cyc"}, 32'(done), 32'd0);
        check({tag, " busy_after_done"}, 32'(busy), 32'd0);
        repeat ($urandom_range(30, 10)) tick();
    endtask

    initial begin
        int unsigned     n_done;
        int unsigned     lat;
        int unsigned     k;
        int unsigned     bad_sel;
        int unsigned     n_edges;
        int unsigned     fast_ch;
        bit              bad;
        logic [N_CH-1:0] fast_set;

        rst      = 1'b1;
        start    = 1'b0;
        ch_sel   = '0;
        start_o  = 1'b0;
        ch_sel_o = '0;
        repeat (10) tick();
        rst = 1'b0;
        tick();

        // Reset state.
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst count", 32'(count), 32'd0);
        check("rst overflow", 32'(overflow), 32'd0);
        check("rst sel_err", 32'(sel_err), 32'd0);
        check("rst state", 32'(u_dut.state_q), 32'(StIdle));
        check("rst en", 32'(u_dut.ring_en_q), 32'd0);
        check("rst ovf_dut count", 32'(count_o), 32'd0);

        // Idle: nothing moves, no ring toggles.
        bad = 1'b0;
        repeat (100) begin
            tick();
            if (busy || done || count != 0 || overflow || sel_err) bad = 1'b1;
            if (u_dut.ring_en_q != 0 || u_dut.ring_raw !== '1) bad = 1'b1;
        end
        check("idle quiet", 32'(bad), 32'd0);

        // Baseline, trojan-loaded chain, baseline again.
        measure_main(0, "ch0 base");
        measure_main(2, "ch2 trojan");
        measure_main(0, "ch0 again");

        // Random healthy channels.
        fast_set = ~SLOW_MASK;
        repeat (2) begin
            do fast_ch = $urandom_range(N_CH - 1, 0); while (!fast_set[fast_ch]);
            measure_main(fast_ch, "rand ch");
        end

        // Out-of-range channel: immediate done with sel_err, no ring.
        bad_sel = $urandom_range(7, N_CH);
        ch_sel  = SEL_W'(bad_sel);
        start   = 1'b1;
        tick();
        start   = 1'b0;
        check("badsel done", 32'(done), 32'd1);
        check("badsel sel_err", 32'(sel_err), 32'd1);
        check("badsel count", 32'(count), 32'd0);
        check("badsel overflow", 32'(overflow), 32'd0);
        check("badsel en", 32'(u_dut.ring_en_q), 32'd0);
        tick();
        check("badsel done_drop", 32'(done), 32'd0);
        check("badsel busy_drop", 32'(busy), 32'd0);
        check("badsel sel_err_held", 32'(sel_err), 32'd1);
        repeat (5) tick();

        // Start pulsed mid-COUNT is ignored: one done, ch1 stays selected.
        ch_sel = 3'd1;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        k      = 0;
        repeat (WARM + 300) begin
            tick();
            k++;
        end
        ch_sel = 3'd3;
        start  = 1'b1;
        tick();
        k++;
        start  = 1'b0;
        check("ignore en", 32'(u_dut.ring_en_q), 32'h2);
        n_done = 0;
        lat    = 0;
        while (k < WARM + GATE + 20) begin
            tick();
            k++;
            if (done) begin
                n_done++;
                if (lat == 0) lat = k;
            end
        end
        check("ignore n_done", n_done, 32'd1);
        check("ignore latency", lat, WARM + GATE);
        check_range("ignore count", 32'(count), exp_edges(FAST_PS), exp_edges(FAST_PS) + 1);
        check("ignore busy", 32'(busy), 32'd0);
        repeat (10) tick();

        // Reset mid-COUNT discards the partial result.
        ch_sel = 3'd0;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        repeat (WARM + $urandom_range(900, 200)) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst state", 32'(u_dut.state_q), 32'(StIdle));
        check("midrst en", 32'(u_dut.ring_en_q), 32'd0);
        check("midrst count", 32'(count), 32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        repeat (20) tick();
        measure_main(0, "post-rst base");

        // Narrow counter saturates.
        n_edges  = exp_edges(FAST_PS);
        ch_sel_o = '0;
        start_o  = 1'b1;
        tick();
        start_o  = 1'b0;
        lat      = 0;
        for (int j = 1; j <= int'(WARM + GATE + 20); j++) begin
            tick();
            if (done_o) begin
                lat = j;
                break;
            end
        end
        check("sat latency", lat, WARM + GATE);
        check("sat count", 32'(count_o), (n_edges > 15) ? 32'd15 : n_edges);
        check("sat overflow", 32'(overflow_o), (n_edges > 15) ? 32'd1 : 32'd0);
        tick();
        check("sat busy", 32'(busy_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
